// File: rtl/if_id_queue.sv
// IF/ID instruction queue: a DEPTH-entry FIFO of {instr, pc, pc4} between fetch and decode.
// Optional IFQ_PERF_CNT_EN adds stall_cnt and flush_cnt performance counters.
module if_id_queue #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_instr,
  input  logic [DATA_WIDTH-1:0]     in_pc,
  input  logic [DATA_WIDTH-1:0]     in_pc4,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_instr,
  output logic [DATA_WIDTH-1:0]     out_pc,
  output logic [DATA_WIDTH-1:0]     out_pc4,
  input  logic                      out_ready,
  input  logic                      flush,
`ifdef IFQ_PERF_CNT_EN
  output logic [31:0]               stall_cnt,
  output logic [31:0]               flush_cnt,
`endif
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0]       FullCnt = CntW'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] Nop     = DATA_WIDTH'(32'h0000_0013);

  logic [DATA_WIDTH-1:0] instr_q [DEPTH];
  logic [DATA_WIDTH-1:0] pc_q    [DEPTH];
  logic [DATA_WIDTH-1:0] pc4_q   [DEPTH];

  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  assign in_ready  = (count_q != FullCnt) && !flush;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  // No bypass: the head is only driven from storage, NOP/zero when empty.
  assign out_instr = out_valid ? instr_q[rptr_q] : Nop;
  assign out_pc    = out_valid ? pc_q[rptr_q]    : '0;
  assign out_pc4   = out_valid ? pc4_q[rptr_q]   : '0;

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PtrW'(1);
      if (pop)  rptr_d = rptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage is never reset; count gates visibility of stale contents.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      instr_q[wptr_q] <= in_instr;
      pc_q[wptr_q]    <= in_pc;
      pc4_q[wptr_q]   <= in_pc4;
    end
  end

`ifdef IFQ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (in_valid && !in_ready && !flush) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush)                           flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus random traffic against a
// queue-based reference model. Honours IFQ_PERF_CNT_EN when defined.
module tb_if_id_queue;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_instr, in_pc, in_pc4;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_instr, out_pc, out_pc4;
  logic          out_ready, flush;
  logic [CW-1:0] count;
`ifdef IFQ_PERF_CNT_EN
  logic [31:0]   stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  if_id_queue #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_instr (in_instr),
    .in_pc    (in_pc),
    .in_pc4   (in_pc4),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_instr(out_instr),
    .out_pc   (out_pc),
    .out_pc4  (out_pc4),
    .out_ready(out_ready),
    .flush    (flush),
`ifdef IFQ_PERF_CNT_EN
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt),
`endif
    .count    (count)
  );

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [DW-1:0] pc;
    logic [DW-1:0] pc4;
  } entry_t;

  entry_t      mq[$];
  int unsigned m_stall, m_flush;
  bit          known;
  int          n_checks, n_fails;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, compare against the model, advance the model.
  task automatic step(input logic v, input logic [DW-1:0] ins, input logic [DW-1:0] pc,
                      input logic ordy, input logic fl, input logic r);
    bit full;
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    in_pc4    = pc + 32'd4;
    out_ready = ordy;
    flush     = fl;
    #1;
    if (known) begin
      check_eq("in_ready", in_ready, (mq.size() != DEPTH) && !fl);
      check_eq("out_valid", out_valid, mq.size() != 0);
      check_eq("out_instr", out_instr, (mq.size() != 0) ? mq[0].instr : 32'h13);
      check_eq("out_pc", out_pc, (mq.size() != 0) ? mq[0].pc : 32'h0);
      check_eq("out_pc4", out_pc4, (mq.size() != 0) ? mq[0].pc4 : 32'h0);
      check_eq("count", count, mq.size());
`ifdef IFQ_PERF_CNT_EN
      check_eq("stall_cnt", stall_cnt, m_stall);
      check_eq("flush_cnt", flush_cnt, m_flush);
`endif
    end
    if (!r) begin
      mq.delete();
      m_stall = 0;
      m_flush = 0;
      known   = 1'b1;
    end else if (known) begin
      full = (mq.size() == DEPTH);
      if (fl) begin
        mq.delete();
        m_flush++;
      end else begin
        if (v && full) m_stall++;
        if (mq.size() != 0 && ordy) void'(mq.pop_front());
        if (v && !full) mq.push_back('{instr: ins, pc: pc, pc4: pc + 32'd4});
      end
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] pc_ctr;
    n_checks = 0;
    n_fails  = 0;
    known    = 1'b0;
    rst = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; in_pc4 = '0;
    out_ready = 1'b0; flush = 1'b0;

    // Reset state
    do_reset();
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_instr", out_instr, 32'h13);
    check_eq("rst_out_pc", out_pc, 32'h0);
    check_eq("rst_out_pc4", out_pc4, 32'h0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_count", count, 0);

    // Single push, latency 1
    step(1'b1, 32'h0050_0093, 32'h0, 1'b0, 1'b0, 1'b1);
    #1;
    check_eq("p1_out_valid", out_valid, 1'b1);
    check_eq("p1_out_instr", out_instr, 32'h0050_0093);
    check_eq("p1_out_pc", out_pc, 32'h0);
    check_eq("p1_out_pc4", out_pc4, 32'h4);
    check_eq("p1_count", count, 1);

    // Overfill then drain in order
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 32'h1000 + i, i * 4, 1'b0, 1'b0, 1'b1);
    #1;
    check_eq("full_count", count, DEPTH);
    check_eq("full_in_ready", in_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_pc", out_pc, i * 4);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
      #1;
    end
    check_eq("drain_nop", out_instr, 32'h13);

    // Steady push+pop at count 2 with pointer wrap
    do_reset();
    for (int i = 0; i < 2; i++) step(1'b1, 32'h2000 + i, 32'h100 + i * 4, 1'b0, 1'b0, 1'b1);
    for (int i = 2; i < 12; i++) begin
      #1;
      check_eq("pp_pc", out_pc, 32'h100 + (i - 2) * 4);
      step(1'b1, 32'h2000 + i, 32'h100 + i * 4, 1'b1, 1'b0, 1'b1);
    end
    #1;
    check_eq("pp_count", count, 2);

    // Flush with push and pop
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 32'h3000 + i, i * 4, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h3333, 32'h40, 1'b1, 1'b1, 1'b1);
    #1;
    check_eq("fl_count", count, 0);
    check_eq("fl_out_valid", out_valid, 1'b0);
    check_eq("fl_out_instr", out_instr, 32'h13);
`ifdef IFQ_PERF_CNT_EN
    check_eq("fl_flush_cnt", flush_cnt, 32'd1);
`endif

    // Reset while full with in_valid
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 32'h4000 + i, i * 4, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h4444, 32'h50, 1'b0, 1'b0, 1'b0);
    #1;
    check_eq("mr_count", count, 0);
    check_eq("mr_in_ready", in_ready, 1'b1);
`ifdef IFQ_PERF_CNT_EN
    check_eq("mr_stall_cnt", stall_cnt, 32'd0);
`endif

    // Random traffic
    pc_ctr = 32'h8000;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, pc_ctr, $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0, $urandom_range(0, 127) != 0);
      pc_ctr = pc_ctr + 32'd4;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
